// File: rtl/mod_exp_pkg.sv
// rtl/mod_exp_pkg.sv - shared constants and FSM state encoding for the modular-exponentiation engine
package mod_exp_pkg;

    localparam int DEF_WIDTH = 16;
    // FSM cycles consumed by one modular multiplication: issue + WIDTH+1 wait/capture.
    localparam int MUL_LAT   = DEF_WIDTH + 2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_SQ   = 3'd2;
    localparam logic [2:0] ST_MUL  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - iterative interleaved shift-add modular multiplier, fixed WIDTH+1 cycle latency
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (returns to idle)
//   start         one-cycle pulse; a, b, n sampled in that cycle (a, b < n)
//   a, b, n       operands and modulus
//   p             a*b mod n, valid while done is high
//   done          one-cycle pulse WIDTH+1 cycles after start
module mod_mul
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [WIDTH:0]   acc_q;

    logic [WIDTH:0] nx, t1, t2, t3, t4;

    // One step per cycle, MSB of a first. acc stays < n, so the doubled
    // value and the value after adding b both fit in WIDTH+1 bits.
    always_comb begin
        nx = {1'b0, n_q};
        t1 = acc_q << 1;
        t2 = (t1 >= nx) ? (t1 - nx) : t1;
        t3 = a_q[WIDTH-1] ? (t2 + {1'b0, b_q}) : t2;
        t4 = (t3 >= nx) ? (t3 - nx) : t3;
    end

    assign p    = acc_q[WIDTH-1:0];
    assign done = run_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            acc_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= CW'(WIDTH);
            a_q   <= a;
            b_q   <= b;
            n_q   <= n;
            acc_q <= '0;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                acc_q <= t4;
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - CW'(1);
            end else begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - left-to-right square-and-multiply modular exponentiation with exact, popcount-dependent latency
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset (aborts any operation)
//   start                       one-cycle request, accepted only when idle
//   base, exponent, modulus     operands, sampled in the accepted start cycle
//   result                      base^exponent mod modulus, held until the next finish
//   finish                      one-cycle pulse when result is valid
//   busy                        high from the cycle after an accepted start through finish
//   err                         set with finish for illegal operands, cleared on next accepted start
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             finish,
    output logic             busy,
    output logic             err
);

    localparam int BW = $clog2(WIDTH);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             bad_q, bad_d;
    logic             err_q, err_d;
    logic             iss_q, iss_d;   // multiply for the current SQ/MUL step already issued

    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_b, mul_p;

    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (r_q),
        .b     (mul_b),
        .n     (n_q),
        .p     (mul_p),
        .done  (mul_done)
    );

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        base_d    = base_q;
        n_d       = n_q;
        exp_d     = exp_q;
        result_d  = result_q;
        bit_d     = bit_q;
        bad_d     = bad_q;
        err_d     = err_q;
        iss_d     = iss_q;
        mul_start = 1'b0;
        mul_b     = (state_q == ST_MUL) ? base_q : r_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    r_d     = WIDTH'(1);
                    base_d  = base;
                    n_d     = modulus;
                    exp_d   = exponent;
                    bit_d   = BW'(WIDTH - 1);
                    bad_d   = (modulus < WIDTH'(2)) || (base >= modulus);
                    err_d   = 1'b0;
                    iss_d   = 1'b1;
                end
            end
            ST_INIT: begin
                // INIT doubles as the issue cycle of the first square, so every
                // multiply costs exactly MUL_LAT cycles including the first.
                // Illegal operands pass through here too, giving finish 2 cycles
                // after start.
                if (bad_q) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    mul_start = 1'b1;
                    state_d   = ST_SQ;
                end
            end
            ST_SQ, ST_MUL: begin
                if (!iss_q) begin
                    mul_start = 1'b1;
                    iss_d     = 1'b1;
                end else if (mul_done) begin
                    r_d   = mul_p;
                    iss_d = 1'b0;
                    if ((state_q == ST_SQ) && exp_q[WIDTH-1]) begin
                        state_d = ST_MUL;
                    end else if (bit_q == '0) begin
                        state_d  = ST_DONE;
                        result_d = mul_p;
                    end else begin
                        state_d = ST_SQ;
                        bit_d   = bit_q - BW'(1);
                        exp_d   = exp_q << 1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            base_q   <= '0;
            n_q      <= '0;
            exp_q    <= '0;
            result_q <= '0;
            bit_q    <= '0;
            bad_q    <= 1'b0;
            err_q    <= 1'b0;
            iss_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            base_q   <= base_d;
            n_q      <= n_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            bit_q    <= bit_d;
            bad_q    <= bad_d;
            err_q    <= err_d;
            iss_q    <= iss_d;
        end
    end

    assign result = result_q;
    assign finish = (state_q == ST_DONE);
    assign busy   = (state_q != ST_IDLE);
    assign err    = err_q;

endmodule

// File: tb/tb_mod_exp.sv
// tb/tb_mod_exp.sv - self-checking testbench for mod_exp against an arithmetic reference model
module tb_mod_exp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [15:0] exponent = '0;
    logic [15:0] modulus = '0;
    logic [15:0] result;
    logic        finish;
    logic        busy;
    logic        err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mod_exp #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .result   (result),
        .finish   (finish),
        .busy     (busy),
        .err      (err)
    );

    function automatic logic illegal(input logic [15:0] b, input logic [15:0] n);
        return (n < 16'd2) || (b >= n);
    endfunction

    function automatic logic [15:0] ref_exp(input logic [15:0] b, input logic [15:0] e,
                                            input logic [15:0] n);
        longint r, bb, nn;
        if (illegal(b, n)) return 16'd0;
        r = 1; bb = longint'(b); nn = longint'(n);
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * bb) % nn;
        end
        return r[15:0];
    endfunction

    function automatic int ref_lat(input logic [15:0] b, input logic [15:0] e,
                                   input logic [15:0] n);
        if (illegal(b, n)) return 2;
        return 1 + 16 * 18 + $countones(e) * 18;
    endfunction

    // Issues one operation and waits for finish; lat = -1 if it never comes.
    task automatic do_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] n,
                         output int lat, output logic [15:0] res, output logic er,
                         output logic busy_gap);
        @(negedge clk);
        base = b; exponent = e; modulus = n; start = 1'b1;
        lat = -1; res = '0; er = 1'b0; busy_gap = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (finish) begin
                lat = c; res = result; er = err;
                break;
            end
            if (!busy) busy_gap = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({result, finish, busy, err} !== 19'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: result=%0d finish=%0b busy=%0b err=%0b want all 0",
                         i, result, finish, busy, err);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || finish !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%0b finish=%0b want 0 0", busy, finish);
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] b, input logic [15:0] e,
                            input logic [15:0] n);
        int lat; logic [15:0] res; logic er, gap;
        do_op(b, e, n, lat, res, er, gap);
        total++;
        if (lat != ref_lat(b, e, n)) begin
            bad++;
            $display("FAIL %s_latency b=%0d e=%0d n=%0d: got=%0d want=%0d", name, b, e, n, lat, ref_lat(b, e, n));
        end
        total++;
        if (res !== ref_exp(b, e, n) || er !== illegal(b, n)) begin
            bad++;
            $display("FAIL %s_result b=%0d e=%0d n=%0d: got=%0d err=%0b want=%0d err=%0b",
                     name, b, e, n, res, er, ref_exp(b, e, n), illegal(b, n));
        end
        total++;
        if (gap) begin
            bad++;
            $display("FAIL %s_busy: busy dropped before finish got=0 want=1", name);
        end
        @(posedge clk); #1;
        total++;
        if (finish !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_after_done: finish=%0b busy=%0b want 0 0", name, finish, busy);
        end
    endtask

    task automatic test_vectors();
        logic [15:0] vb[4] = '{16'd65, 16'd2576, 16'd1234, 16'd0};
        logic [15:0] ve[4] = '{16'd3, 16'd2011, 16'd0, 16'd5};
        for (int i = 0; i < 4; i++) check_op("vector", vb[i], ve[i], 16'd3127);
    endtask

    task automatic test_illegal();
        logic [15:0] n;
        check_op("illegal_b_eq_n", 16'd3127, 16'd3, 16'd3127);
        check_op("illegal_n1", 16'd0, 16'd7, 16'd1);
        check_op("illegal_n0", 16'd0, 16'd9, 16'd0);
        n = 16'($urandom_range(2, 60000));
        check_op("illegal_rand", 16'($urandom_range(n, 65535)), 16'($urandom), n);
    endtask

    task automatic test_random();
        logic [15:0] n, b, e;
        for (int i = 0; i < 8; i++) begin
            n = 16'($urandom_range(2, 65535));
            b = 16'($urandom % n);
            e = 16'($urandom);
            check_op("random", b, e, n);
        end
        check_op("random_e_all_ones", 16'($urandom_range(0, 65520)), 16'hffff, 16'd65521);
    endtask

    task automatic test_ignored_start();
        int lat; logic [15:0] res;
        @(negedge clk);
        base = 16'd2576; exponent = 16'd2011; modulus = 16'd3127; start = 1'b1;
        lat = -1; res = '0;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 50) begin
                base = 16'd5; exponent = 16'd7; modulus = 16'd11; start = 1'b1;
            end
            if (finish) begin lat = c; res = result; break; end
        end
        total++;
        if (lat != 451 || res !== 16'd65) begin
            bad++;
            $display("FAIL ignored_start: got lat=%0d result=%0d want lat=451 result=65", lat, res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat; logic [15:0] res; logic er, gap; logic seen;
        @(negedge clk);
        base = 16'd2576; exponent = 16'd2011; modulus = 16'd3127; start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || result !== 16'd0 || finish !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: busy=%0b result=%0d finish=%0b want 0 0 0", busy, result, finish);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 450; c++) begin
            @(posedge clk); #1;
            if (finish || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_abort_quiet: got activity=1 want 0");
        end
        do_op(16'd65, 16'd3, 16'd3127, lat, res, er, gap);
        total++;
        if (lat != 325 || res !== ref_exp(16'd65, 16'd3, 16'd3127) || er !== 1'b0) begin
            bad++;
            $display("FAIL fresh_after_reset: got lat=%0d result=%0d err=%0b want lat=325 result=%0d err=0",
                     lat, res, er, ref_exp(16'd65, 16'd3, 16'd3127));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] res; logic er, gap;
        do_op(16'd65, 16'd3, 16'd3127, lat, res, er, gap);
        // Now in the DONE cycle: a start here must be ignored, the next cycle accepted.
        base = 16'd1234; exponent = 16'd0; modulus = 16'd3127; start = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || finish !== 1'b0 || result !== 16'd2576) begin
            bad++;
            $display("FAIL start_in_done: busy=%0b finish=%0b result=%0d want 0 0 2576", busy, finish, result);
        end
        lat = -1;
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (finish) begin lat = c; res = result; break; end
        end
        total++;
        if (lat != 289 || res !== 16'd1) begin
            bad++;
            $display("FAIL start_after_done: got lat=%0d result=%0d want lat=289 result=1", lat, res);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_illegal();
        test_random();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
